bp_fe_queue_rollback_fifo: RTL and testbench

- FE-side storage for the FE queue. It accepts fetched-instruction/exception packets from the front-end and presents them to the back-end.
- Responds to the back-end queue controls: yumi (speculative read), deq (commit), roll (rewind reads to the last commit), clr (flush uncommitted).
- Sits between the FE pc-gen/fetch logic and the BE queue-consumer interface.

---
 rtl/bp_fe_pkg.sv | 19 +
 rtl/bp_fe_queue_ptr_ctrl.sv | 87 ++++++++
 rtl/bsg_mem_1r1w.sv | 34 +++
 rtl/bp_fe_queue_rollback_fifo.sv | 58 +++++
 tb/tb_bp_fe_queue_rollback_fifo.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_fe_pkg.sv
// Shared front-end definitions: the FE queue packet layout and the queue pointer sizing helper.
package bp_fe_pkg;

    typedef struct packed {
        logic [1:0]  msg_type;
        logic [50:0] padding;
        logic [3:0]  exc_code;
        logic [38:0] pc;
        logic [31:0] instr;
    } bp_fe_queue_s;

    localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

    // One extra bit beyond the address bits serves as the wrap bit.
    function automatic int bp_fe_queue_ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_fe_queue_ptr_ctrl.sv
// Write / speculative-read / commit pointers of the FE rollback queue, with full/valid
// derivation and resolution of clr, roll, yumi, deq and enqueue.
module bp_fe_queue_ptr_ctrl
    import bp_fe_pkg::*;
#(
    parameter int els_p = 8,
    localparam int ptr_w = bp_fe_queue_ptr_width(els_p),
    localparam int addr_w = ptr_w - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enq_v,
    input  logic              yumi,
    input  logic              deq,
    input  logic              roll,
    input  logic              clr,
    output logic              enq_ready,
    output logic              read_v,
    output logic              write_en,
    output logic [addr_w-1:0] waddr,
    output logic [addr_w-1:0] raddr
);

    logic [ptr_w-1:0] wptr, rptr, cptr;
    logic [ptr_w-1:0] wptr_next, rptr_next, cptr_next;
    logic [ptr_w-1:0] rd_span, wr_span;
    logic             full, yumi_ok, deq_ok, enq_ok;

    // Occupancy is measured from the commit point so unrolled entries are never overwritten.
    assign full      = (wptr[addr_w-1:0] == cptr[addr_w-1:0]) && (wptr[addr_w] != cptr[addr_w]);
    assign enq_ready = ~full;
    assign read_v    = (rptr != wptr);

    assign yumi_ok  = yumi & read_v;
    assign deq_ok   = deq & (cptr != rptr);
    assign enq_ok   = enq_v & ~full;
    assign write_en = enq_ok & ~clr;

    // Deq lands first so roll and clr rewind to the freshly advanced commit point.
    assign cptr_next = cptr + ptr_w'(deq_ok);

    always_comb begin
        rptr_next = rptr;
        if (clr || roll) begin
            rptr_next = cptr_next;
        end else if (yumi_ok) begin
            rptr_next = rptr + 1'b1;
        end

        wptr_next = wptr;
        if (clr) begin
            wptr_next = cptr_next;
        end else if (enq_ok) begin
            wptr_next = wptr + 1'b1;
        end
    end

    assign waddr = wptr[addr_w-1:0];
    assign raddr = rptr[addr_w-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
            cptr <= cptr_next;
        end
    end

    assign rd_span = rptr - cptr;
    assign wr_span = wptr - cptr;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(yumi && !read_v))
                else $error("fe_queue: yumi with no unread entry");
            assert (!(deq && (cptr == rptr)))
                else $error("fe_queue: deq with no read-but-uncommitted entry");
            assert ((rd_span <= wr_span) && (wr_span <= ptr_w'(els_p)))
                else $error("fe_queue: pointer ordering violated");
        end
    end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-write-port, one-read-port register array; clocked write, asynchronous read.
module bsg_mem_1r1w #(
    parameter int width_p = 128,
    parameter int els_p = 8,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_w = $clog2(els_p)
) (
    input  logic               w_clk_i,
    input  logic               w_v_i,
    input  logic [addr_w-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic               r_v_i,
    input  logic [addr_w-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_v_i ? mem[r_addr_i] : '0;

    always_ff @(posedge w_clk_i) begin
        if (read_write_same_addr_p == 0) begin
            assert (!(w_v_i && r_v_i && (w_addr_i == r_addr_i)))
                else $error("bsg_mem_1r1w: read and write to the same address");
        end
    end

endmodule

// File: rtl/bp_fe_queue_rollback_fifo.sv
// FE queue storage with speculative reads: packets stay resident until the BE commits them,
// so a roll can replay them and a clr can drop everything not yet committed.
module bp_fe_queue_rollback_fifo
    import bp_fe_pkg::*;
#(
    parameter int els_p = 8,
    parameter int width_p = fe_queue_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] enq_data_i,
    input  logic               enq_v_i,
    output logic               enq_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);

    localparam int addr_w = bp_fe_queue_ptr_width(els_p) - 1;

    logic [addr_w-1:0] waddr, raddr;
    logic              write_en;

    bp_fe_queue_ptr_ctrl #(
        .els_p(els_p)
    ) ptr_ctrl (
        .clk      (clk_i),
        .reset_n  (reset_n_i),
        .enq_v    (enq_v_i),
        .yumi     (fe_queue_yumi_i),
        .deq      (fe_queue_deq_i),
        .roll     (fe_queue_roll_i),
        .clr      (fe_queue_clr_i),
        .enq_ready(enq_ready_o),
        .read_v   (fe_queue_v_o),
        .write_en (write_en),
        .waddr    (waddr),
        .raddr    (raddr)
    );

    bsg_mem_1r1w #(
        .width_p               (width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(0)
    ) mem (
        .w_clk_i (clk_i),
        .w_v_i   (write_en),
        .w_addr_i(waddr),
        .w_data_i(enq_data_i),
        .r_v_i   (fe_queue_v_o),
        .r_addr_i(raddr),
        .r_data_o(fe_queue_o)
    );

endmodule

// File: tb/tb_bp_fe_queue_rollback_fifo.sv
// Bench for the FE rollback queue: a vector table for basic ordering plus hand sequences
// for fill, roll, clr, wrap-around and mid-stream reset.
module tb_bp_fe_queue_rollback_fifo;

    localparam int els_lp = 8;
    localparam int width_lp = 128;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [width_lp-1:0] enq_data = '0;
    logic                enq_v = 1'b0;
    logic                enq_ready;
    logic [width_lp-1:0] fe_queue;
    logic                fe_queue_v;
    logic                yumi = 1'b0;
    logic                deq = 1'b0;
    logic                roll = 1'b0;
    logic                clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [width_lp-1:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic       enq_v;
        logic [7:0] data;
        logic       yumi;
        logic       deq;
        logic       roll;
        logic       clr;
        logic       exp_ready;
        logic       exp_v;
        logic       chk_d;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[14];

    bp_fe_queue_rollback_fifo #(
        .els_p  (els_lp),
        .width_p(width_lp)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .enq_data_i     (enq_data),
        .enq_v_i        (enq_v),
        .enq_ready_o    (enq_ready),
        .fe_queue_o     (fe_queue),
        .fe_queue_v_o   (fe_queue_v),
        .fe_queue_yumi_i(yumi),
        .fe_queue_deq_i (deq),
        .fe_queue_roll_i(roll),
        .fe_queue_clr_i (clr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, ev, input logic [7:0] d, input logic y, dq, rl, cl,
                                input logic er, evv, cd, input logic [7:0] ed);
        vec_t v;
        v.rst_n = r; v.enq_v = ev; v.data = d; v.yumi = y; v.deq = dq; v.roll = rl; v.clr = cl;
        v.exp_ready = er; v.exp_v = evv; v.chk_d = cd; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [width_lp-1:0] act, input logic [width_lp-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0h expected <scoreboard empty>", name, fe_queue);
        end else begin
            chk(name, fe_queue, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [width_lp-1:0] d, input logic y, dq, rl, cl);
        enq_v = ev; enq_data = d; yumi = y; deq = dq; roll = rl; clr = cl;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        vecs[1]  = mk(1, 1, 8'hA1, 0, 0, 0, 0, 1, 1, 1, 8'hA1);
        vecs[2]  = mk(1, 1, 8'hA2, 0, 0, 0, 0, 1, 1, 1, 8'hA1);
        vecs[3]  = mk(1, 1, 8'hA3, 0, 0, 0, 0, 1, 1, 1, 8'hA1);
        vecs[4]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 8'hA2);
        vecs[5]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 8'hA3);
        vecs[6]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        vecs[7]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00);
        vecs[8]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00);
        vecs[9]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00);
        vecs[10] = mk(1, 1, 8'hD0, 0, 0, 0, 0, 1, 1, 1, 8'hD0);
        vecs[11] = mk(1, 1, 8'hD1, 1, 0, 0, 0, 1, 1, 1, 8'hD1);
        vecs[12] = mk(1, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'h00);
        vecs[13] = mk(1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00);

        // Vector table: reset, in-order enqueue/read, commit.
        for (int i = 0; i < 14; i++) begin
            reset_n = vecs[i].rst_n;
            drive(vecs[i].enq_v, width_lp'(vecs[i].data), vecs[i].yumi, vecs[i].deq,
                  vecs[i].roll, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d_ready", i), width_lp'(enq_ready), width_lp'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_v", i), width_lp'(fe_queue_v), width_lp'(vecs[i].exp_v));
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_data", i), fe_queue, width_lp'(vecs[i].exp_d));
            end
        end
        reset_n = 1'b1;

        // Fill to capacity; reads alone must not free space, a commit must.
        do_reset();
        for (int i = 0; i < els_lp; i++) begin
            exp_q.push_back(width_lp'(8'hF0 + i));
            drive(1'b1, width_lp'(8'hF0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("fill_ready%0d", i), width_lp'(enq_ready), width_lp'(i < els_lp - 1));
        end
        for (int i = 0; i < els_lp; i++) begin
            drive(1'b1, width_lp'(8'hEE), 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            pop_chk($sformatf("fill_read%0d", i));
            tick();
            chk($sformatf("fill_ready_hold%0d", i), width_lp'(enq_ready), '0);
        end
        idle();
        chk("fill_empty_v", width_lp'(fe_queue_v), '0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("fill_deq_ready", width_lp'(enq_ready), width_lp'(1));

        // Roll back to the commit point, including deq+roll and yumi+roll in one cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, width_lp'(8'hB0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("roll_read_b0", fe_queue, width_lp'(8'hB0));
        tick();
        #1;
        chk("roll_read_b1", fe_queue, width_lp'(8'hB1));
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk("roll_head", fe_queue, width_lp'(8'hB1));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        chk("roll_reread_b1", fe_queue, width_lp'(8'hB1));
        tick();
        #1;
        chk("roll_reread_b2", fe_queue, width_lp'(8'hB2));
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        chk("deq_roll_head", fe_queue, width_lp'(8'hB2));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk("yumi_roll_head", fe_queue, width_lp'(8'hB2));
        chk("yumi_roll_v", width_lp'(fe_queue_v), width_lp'(1));

        // Clr together with deq and an enqueue: the enqueue is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, width_lp'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
            chk($sformatf("clr_read%0d", i), fe_queue, width_lp'(8'h30 + i));
            tick();
        end
        drive(1'b1, width_lp'(8'h99), 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        chk("clr_v", width_lp'(fe_queue_v), '0);
        chk("clr_ready", width_lp'(enq_ready), width_lp'(1));
        drive(1'b1, width_lp'(8'hC0), 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("clr_next_v", width_lp'(fe_queue_v), width_lp'(1));
        chk("clr_next_data", fe_queue, width_lp'(8'hC0));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("clr_after_read_v", width_lp'(fe_queue_v), '0);

        // Streaming across several pointer wraps with read+commit every cycle.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("wrap_ready%0d", i), width_lp'(enq_ready), width_lp'(1));
            if (i < 20) exp_q.push_back(width_lp'(i));
            drive(i < 20, width_lp'(i), (i >= 1) && (i <= 20), i >= 2, 1'b0, 1'b0);
            #1;
            if ((i >= 1) && (i <= 20)) pop_chk($sformatf("wrap_data%0d", i - 1));
            tick();
        end
        idle();
        chk("wrap_drained_v", width_lp'(fe_queue_v), '0);
        chk("wrap_sb_empty", width_lp'(exp_q.size()), '0);

        // Reset while entries are queued discards them.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, width_lp'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        reset_n = 1'b0;
        idle();
        tick();
        reset_n = 1'b1;
        chk("midrst_v", width_lp'(fe_queue_v), '0);
        chk("midrst_ready", width_lp'(enq_ready), width_lp'(1));
        drive(1'b1, width_lp'(8'h77), 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("midrst_new_v", width_lp'(fe_queue_v), width_lp'(1));
        chk("midrst_new_data", fe_queue, width_lp'(8'h77));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("midrst_empty_v", width_lp'(fe_queue_v), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
